axil_reg_master: RTL and testbench

AXI4-Lite initiator that turns single-beat register commands into AXI-Lite read or write transactions. Used by shell self-test logic and role-side control to access AXI-Lite slaves such as axil_dummy (reading its magic number) and user register banks. Accepts one command at a time, drives the AXI-Lite master channels, returns data and response, and aborts on timeout.

---
 rtl/axil_pkg.sv | 33 +++
 rtl/axil_reg_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axil_reg_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared types and constants for the AXI4-Lite register master:
//                FSM state encoding, AXI response codes, default data width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_pkg;

    // Only a 32-bit data path is supported by the master.
    localparam int c_DEFAULT_DATA_WIDTH = 32;

    // AXI BRESP/RRESP encodings
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Master FSM: WR = AW and/or W still outstanding, WB = waiting for B,
    // RA = AR outstanding, RD = waiting for R, DONE = one-cycle response.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage : axil_pkg

`default_nettype wire

// File: rtl/axil_reg_master.sv
// ============================================================================
//  Module      : axil_reg_master
//  Description : AXI4-Lite initiator. Accepts one register command at a time,
//                runs a single-beat AXI-Lite read or write, and returns the
//                data/response as a one-cycle pulse.
//                Optional macro AXIL_TIMEOUT_EN: abort a transaction that has
//                not completed within TIMEOUT_CYC cycles (rsp_timeout=1,
//                rsp_resp=SLVERR). Without it the master waits indefinitely.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_reg_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      sys_clk,
    input  logic                      rst,

    // command / response interface
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    // AXI4-Lite master
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    localparam int c_STRB_W = DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (DATA_WIDTH != 32) begin : g_dw_check
            $error("axil_reg_master: DATA_WIDTH must be 32");
        end
        if (TIMEOUT_CYC < 2) begin : g_tmo_check
            $error("axil_reg_master: TIMEOUT_CYC must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr,    w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata_nxt;
    logic [c_STRB_W-1:0]     r_wstrb,   w_wstrb_nxt;
    logic                    r_awvalid, w_awvalid_nxt;
    logic                    r_wvalid,  w_wvalid_nxt;
    logic                    r_bready,  w_bready_nxt;
    logic                    r_arvalid, w_arvalid_nxt;
    logic                    r_rready,  w_rready_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata,   w_rdata_nxt;
    logic [1:0]              r_resp,    w_resp_nxt;
    logic                    w_busy;

`ifdef AXIL_TIMEOUT_EN
    localparam int c_TCNT_W = $clog2(TIMEOUT_CYC) + 1;
    // The abort decision is taken one cycle early so that DONE coincides
    // with the counter reaching TIMEOUT_CYC-1.
    localparam logic [c_TCNT_W-1:0] c_TCNT_ABORT = c_TCNT_W'(TIMEOUT_CYC - 2);

    logic [c_TCNT_W-1:0]     r_tcnt,    w_tcnt_nxt;
    logic                    r_timeout, w_timeout_nxt;
`endif

    assign w_busy = (r_state == ST_WR) || (r_state == ST_WB) ||
                    (r_state == ST_RA) || (r_state == ST_RD);

    // Next-state, channel handshake and response capture logic
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_rdata_nxt   = r_rdata;
        w_resp_nxt    = r_resp;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_wdata;
                    w_wstrb_nxt = cmd_wstrb;
                    if (cmd_wr) begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RA;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently, in any order
                if (r_awvalid && m_axil_awready) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (r_wvalid && m_axil_wready) begin
                    w_wvalid_nxt = 1'b0;
                end
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = ST_WB;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WB: begin
                if (m_axil_bvalid) begin
                    w_state_nxt  = ST_DONE;
                    w_bready_nxt = 1'b0;
                    w_resp_nxt   = m_axil_bresp;
                    w_rdata_nxt  = '0;
                end
            end
            ST_RA: begin
                if (m_axil_arready) begin
                    w_state_nxt   = ST_RD;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD: begin
                if (m_axil_rvalid) begin
                    w_state_nxt  = ST_DONE;
                    w_rready_nxt = 1'b0;
                    w_resp_nxt   = m_axil_rresp;
                    w_rdata_nxt  = m_axil_rdata;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
            end
        endcase

`ifdef AXIL_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
        w_timeout_nxt = r_timeout;
        if (r_state == ST_IDLE && cmd_valid) begin
            w_tcnt_nxt = '0;
        end else if (w_busy) begin
            w_tcnt_nxt = r_tcnt + 1'b1;
        end
        // A genuine completion in the same cycle wins over the abort.
        if (w_busy && (w_state_nxt == ST_DONE)) begin
            w_timeout_nxt = 1'b0;
        end else if (w_busy && (r_tcnt == c_TCNT_ABORT)) begin
            w_state_nxt   = ST_DONE;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_rdata_nxt   = '0;
            w_resp_nxt    = c_RESP_SLVERR;
            w_timeout_nxt = 1'b1;
        end
`endif
    end

    // State register and registered channel/response outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= c_RESP_OKAY;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_rdata   <= w_rdata_nxt;
            r_resp    <= w_resp_nxt;
        end
    end

`ifdef AXIL_TIMEOUT_EN
    // Per-transaction cycle counter and timeout flag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tcnt    <= w_tcnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign rsp_timeout = r_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign cmd_ready      = (r_state == ST_IDLE);
    assign rsp_valid      = (r_state == ST_DONE);
    assign rsp_rdata      = r_rdata;
    assign rsp_resp       = r_resp;

    assign m_axil_awaddr  = r_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_addr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule : axil_reg_master

`default_nettype wire

// File: tb/tb_axil_reg_master.sv
// ============================================================================
//  Module      : tb_axil_reg_master
//  Description : Self-checking bench for axil_reg_master with a configurable
//                AXI-Lite slave (magic word at 0x0, 15 scratch words above it)
//                and a word-array reference model of register contents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_master;

    localparam int          c_TMO   = 16;
    localparam logic [31:0] c_MAGIC = 32'h0011_4514;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    axil_reg_master #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .TIMEOUT_CYC (c_TMO)
    ) u_dut (
        .sys_clk        (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .m_axil_awaddr  (awaddr),
        .m_axil_awprot  (awprot),
        .m_axil_awvalid (awvalid),
        .m_axil_awready (s_awready),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wvalid  (wvalid),
        .m_axil_wready  (s_wready),
        .m_axil_bresp   (s_bresp),
        .m_axil_bvalid  (s_bvalid),
        .m_axil_bready  (bready),
        .m_axil_araddr  (araddr),
        .m_axil_arprot  (arprot),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (s_arready),
        .m_axil_rdata   (s_rdata),
        .m_axil_rresp   (s_rresp),
        .m_axil_rvalid  (s_rvalid),
        .m_axil_rready  (rready)
    );

    // ------------------------------------------------------------------
    // Slave configuration (written only by the main sequence)
    // ------------------------------------------------------------------
    int         k_aw_lat = 0, k_w_lat = 0, k_b_lat = 0, k_ar_lat = 0, k_r_lat = 0;
    bit         k_rnd = 1'b0;
    logic [1:0] k_bresp = 2'b00, k_rresp = 2'b00;
    bit         mon_en = 1'b1;

    function automatic int pick(input int cfg_lat);
        return k_rnd ? int'($urandom_range(0, 3)) : cfg_lat;
    endfunction

    // ------------------------------------------------------------------
    // Slave: ready after a per-channel wait, B/R after a response latency
    // ------------------------------------------------------------------
    logic [31:0] s_mem [16] = '{default: 32'h0};
    int          aw_wait, w_wait, ar_wait, cur_aw, cur_w, cur_ar, b_cnt, r_cnt, cur_b, cur_r;
    bit          got_aw, got_w, b_busy, b_done, r_busy, r_done;
    logic [31:0] sa, sd, ra;
    logic [3:0]  ss;

    always @(posedge clk) begin
        if (rst) begin
            s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
            s_bvalid  <= 1'b0; s_rvalid <= 1'b0;
            s_bresp   <= 2'b00; s_rresp <= 2'b00; s_rdata <= 32'h0;
            got_aw = 0; got_w = 0; b_busy = 0; b_done = 0; r_busy = 0; r_done = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; cur_aw = 0; cur_w = 0; cur_ar = 0;
        end else begin
            if (awvalid && s_awready) begin got_aw = 1; sa = awaddr; end
            if (!awvalid || s_awready) begin aw_wait = 0; cur_aw = pick(k_aw_lat); end
            else aw_wait++;
            s_awready <= (aw_wait >= cur_aw);

            if (wvalid && s_wready) begin got_w = 1; sd = wdata; ss = wstrb; end
            if (!wvalid || s_wready) begin w_wait = 0; cur_w = pick(k_w_lat); end
            else w_wait++;
            s_wready <= (w_wait >= cur_w);

            if (s_bvalid && bready) begin s_bvalid <= 1'b0; b_busy = 0; end
            if (got_aw && got_w) begin
                if (sa[5:2] != 4'd0) begin
                    for (int i = 0; i < 4; i++)
                        if (ss[i]) s_mem[sa[5:2]][8*i +: 8] = sd[8*i +: 8];
                end
                got_aw = 0; got_w = 0; b_busy = 1; b_done = 0; b_cnt = 0; cur_b = pick(k_b_lat);
            end
            if (b_busy && !b_done) begin
                if (b_cnt >= cur_b) begin s_bvalid <= 1'b1; s_bresp <= k_bresp; b_done = 1; end
                else b_cnt++;
            end

            if (s_rvalid && rready) begin s_rvalid <= 1'b0; r_busy = 0; end
            if (arvalid && s_arready) begin
                r_busy = 1; r_done = 0; ra = araddr; r_cnt = 0; cur_r = pick(k_r_lat);
            end
            if (!arvalid || s_arready) begin ar_wait = 0; cur_ar = pick(k_ar_lat); end
            else ar_wait++;
            s_arready <= (ar_wait >= cur_ar);
            if (r_busy && !r_done) begin
                if (r_cnt >= cur_r) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= (ra[5:2] == 4'd0) ? c_MAGIC : s_mem[ra[5:2]];
                    s_rresp  <= k_rresp;
                    r_done = 1;
                end else r_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol monitor: a pending valid must stay high with stable payload
    // ------------------------------------------------------------------
    int          mon_viol = 0;
    bit          p_ok = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;

    always @(negedge clk) begin
        if (mon_en && !rst && p_ok) begin
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awa)) mon_viol++;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wd || wstrb != p_ws)) mon_viol++;
            if (p_arv && !p_arr && (!arvalid || araddr != p_ara)) mon_viol++;
        end
        p_awv = awvalid; p_awr = s_awready; p_awa = awaddr;
        p_wv  = wvalid;  p_wr  = s_wready;  p_wd  = wdata; p_ws = wstrb;
        p_arv = arvalid; p_arr = s_arready; p_ara = araddr;
        p_ok  = !rst;
    end

    // ------------------------------------------------------------------
    // Reference model: word array; word 0 is a read-only magic number
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] d,
                                        input logic [3:0] strb);
        int idx = int'(addr[5:2]);
        if (idx == 0) return;
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8*b))) |
                                        (d & (32'hFF << (8*b)));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return (addr[5:2] == 4'd0) ? c_MAGIC : ref_mem[addr[5:2]];
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command, return the response and cycles from accept to rsp_valid
    // (-1 when no response arrives within the budget).
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] d,
                         input logic [3:0] strb, output logic [31:0] rd,
                         output logic [1:0] rs, output logic to, output int lat);
        int n;
        bit got;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; got = 0; rd = 32'h0; rs = 2'b00; to = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
            end
        end
        if (!got) lat = -1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
        logic [1:0]  bresp, rresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] g_rd;
    logic [1:0]  g_rs;
    logic        g_to;
    int          g_lat;
    int          pulses;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr  addr   wdata         strb aw w  b  ar r  bresp rresp exp_rdata     resp lat
        vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0011_4514, 2'b00, 3};
        vecs[1]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 3, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 6};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF,  2'b00, 3};
        vecs[3]  = '{1'b1, 32'h08, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3};
        vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0022_0044, 2'b00, 3};
        vecs[5]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h0,         2'b10, 3};
        vecs[6]  = '{1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0,         2'b11, 3};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 2'b00, 32'hCAFEF00D,  2'b00, 6};
        vecs[8]  = '{1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 2, 0, 2, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 7};
        vecs[9]  = '{1'b0, 32'h14, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A5A5A5,  2'b00, 3};
        vecs[10] = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3};
        vecs[11] = '{1'b0, 32'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0011_4514, 2'b00, 3};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_axi_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
        check("rst_rsp_flags", {28'h0, rsp_valid, rsp_timeout, rsp_resp}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_addr", awaddr | araddr | wdata, 32'h0);
        check("rst_prot", {26'h0, awprot, arprot}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed table
        for (int i = 0; i < 12; i++) begin
            k_aw_lat = vecs[i].aw_lat; k_w_lat = vecs[i].w_lat; k_b_lat = vecs[i].b_lat;
            k_ar_lat = vecs[i].ar_lat; k_r_lat = vecs[i].r_lat;
            k_bresp  = vecs[i].bresp;  k_rresp = vecs[i].rresp;
            @(negedge clk);
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, g_rd, g_rs, g_to, g_lat);
            if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_resp", i), {30'h0, g_rs}, {30'h0, vecs[i].exp_resp});
            check($sformatf("vec%0d_timeout", i), {31'h0, g_to}, 32'h0);
            check($sformatf("vec%0d_latency", i), g_lat, vecs[i].exp_lat);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_idle", i), {30'h0, rsp_valid, cmd_ready}, 32'h1);
            check($sformatf("vec%0d_rdata_hold", i), rsp_rdata, vecs[i].exp_rdata);
        end
        k_bresp = 2'b00; k_rresp = 2'b00;

        // randomized stalls, mixed commands, checked against the model
        k_rnd = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic        wr;
            logic [31:0] addr, d, exp;
            logic [3:0]  strb;
            wr   = 1'($urandom_range(0, 1));
            addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            d    = $urandom;
            strb = 4'($urandom_range(0, 15));
            exp  = wr ? 32'h0 : model_read(addr);
            issue(wr, addr, d, strb, g_rd, g_rs, g_to, g_lat);
            if (wr) model_write(addr, d, strb);
            check($sformatf("rnd%0d_rdata", i), g_rd, exp);
            check($sformatf("rnd%0d_resp_to", i), {29'h0, g_to, g_rs}, 32'h0);
            check($sformatf("rnd%0d_seen", i), {31'h0, (g_lat > 0)}, 32'h1);
        end
        k_rnd = 1'b0;
        k_aw_lat = 0; k_w_lat = 0; k_b_lat = 0; k_ar_lat = 0; k_r_lat = 0;

`ifdef AXIL_TIMEOUT_EN
        // slave never accepts AR: abort after c_TMO cycles
        mon_en = 1'b0;
        k_ar_lat = 100000;
        @(negedge clk);
        issue(1'b0, 32'h08, 32'h0, 4'h0, g_rd, g_rs, g_to, g_lat);
        check("tmo_flag", {31'h0, g_to}, 32'h1);
        check("tmo_resp", {30'h0, g_rs}, 32'h2);
        check("tmo_rdata", g_rd, 32'h0);
        check("tmo_latency", g_lat, c_TMO);
        @(negedge clk);
        check("tmo_idle", {30'h0, cmd_ready, arvalid}, 32'h2);
        k_ar_lat = 0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
`endif

        // asynchronous reset while waiting for B
        k_b_lat = 40;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int n = 0; n < 20 && !bready; n++) @(negedge clk);
        check("rst_wb_reached", {31'h0, bready}, 32'h1);
        model_write(32'h3C, 32'h12345678, 4'hF);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
        check("rst_async_ready", {30'h0, cmd_ready, rsp_valid}, 32'h2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        k_b_lat = 0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst_no_rsp_pulse", pulses, 0);
        issue(1'b0, 32'h3C, 32'h0, 4'h0, g_rd, g_rs, g_to, g_lat);
        check("rst_recover_rdata", g_rd, model_read(32'h3C));
        check("rst_recover_latency", g_lat, 3);

        check("valid_stable", mon_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axil_reg_master

`default_nettype wire
